// File: rtl/lfsr_range_rng.sv
// Free-running Fibonacci LFSR with reseed and zero-lockup guard, delivering an
// unbiased value in [0, RANGE-1] per request through rejection sampling.
module lfsr_range_rng #(
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1,
  parameter int                    OUT_WIDTH  = 2,
  parameter int                    RANGE      = 4,
  parameter int                    MAX_TRIES  = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  input  logic                  req,
  output logic                  busy,
  output logic                  rnd_valid,
  output logic [OUT_WIDTH-1:0]  rnd_out,
  output logic                  rnd_fallback,
  output logic [LFSR_WIDTH-1:0] lfsr_state
);

  localparam int                    TRY_W     = $clog2(MAX_TRIES) + 1;
  localparam logic [LFSR_WIDTH-1:0] ONE       = LFSR_WIDTH'(1);
  localparam logic [LFSR_WIDTH-1:0] SEED_SAFE = (SEED == '0) ? ONE : SEED;
  localparam logic [OUT_WIDTH:0]    RANGE_X   = (OUT_WIDTH+1)'(RANGE);
  localparam logic [TRY_W-1:0]      LAST_TRY  = TRY_W'(MAX_TRIES - 1);
  localparam logic [OUT_WIDTH-1:0]  FORCED    = OUT_WIDTH'(RANGE - 1);

  typedef enum logic {IDLE, SAMPLE} state_t;

  state_t                state, state_nxt;
  logic [LFSR_WIDTH-1:0] lfsr, lfsr_nxt;
  logic [TRY_W-1:0]      tries, tries_nxt;
  logic [OUT_WIDTH-1:0]  cand, out_nxt;
  logic                  valid_nxt, fallback_nxt, busy_nxt, accept;

  // Reseed wins; a zero register (only reachable through odd tap masks) is
  // forced back to 1 rather than shifted, so the sequence can never stall.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(
    input logic [LFSR_WIDTH-1:0] cur,
    input logic                  ld,
    input logic [LFSR_WIDTH-1:0] sd
  );
    if (ld)
      return (sd == '0) ? ONE : sd;
    else if (cur == '0)
      return ONE;
    else
      return {cur[LFSR_WIDTH-2:0], ^(cur & TAPS)};
  endfunction

  assign cand       = lfsr[OUT_WIDTH-1:0];
  assign accept     = {1'b0, cand} < RANGE_X;
  assign lfsr_nxt   = lfsr_step(lfsr, seed_load, seed_in);
  assign lfsr_state = lfsr;

  always_comb begin
    state_nxt    = state;
    tries_nxt    = tries;
    out_nxt      = rnd_out;
    valid_nxt    = 1'b0;
    fallback_nxt = 1'b0;
    busy_nxt     = busy;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = SAMPLE;
          busy_nxt  = 1'b1;
          tries_nxt = '0;
        end
      end
      SAMPLE: begin
        if (accept) begin
          out_nxt   = cand;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (tries == LAST_TRY) begin
          out_nxt      = FORCED;
          valid_nxt    = 1'b1;
          fallback_nxt = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = IDLE;
        end else begin
          tries_nxt = tries + TRY_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      lfsr         <= SEED_SAFE;
      tries        <= '0;
      rnd_out      <= '0;
      rnd_valid    <= 1'b0;
      rnd_fallback <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      lfsr         <= lfsr_nxt;
      tries        <= tries_nxt;
      rnd_out      <= out_nxt;
      rnd_valid    <= valid_nxt;
      rnd_fallback <= fallback_nxt;
      busy         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Bench for lfsr_range_rng: default, RANGE=3 and RANGE=1/MAX_TRIES=2 instances
// share one stimulus stream; default results are scoreboarded against a model.
module tb_lfsr_range_rng;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        req = 1'b0;

  logic        d_busy, d_valid, d_fb;
  logic [1:0]  d_out;
  logic [15:0] d_lfsr;
  logic        t_busy, t_valid, t_fb;
  logic [1:0]  t_out;
  logic [15:0] t_lfsr;
  logic        o_busy, o_valid, o_fb;
  logic [1:0]  o_out;
  logic [15:0] o_lfsr;

  int total = 0;
  int passed = 0;
  int valid_cnt = 0;

  logic [15:0] m_lfsr;
  logic        m_busy;
  logic [1:0]  q_def[$];

  always #10 CLOCK_50 = ~CLOCK_50;

  lfsr_range_rng u_def (
    .CLOCK_50(CLOCK_50), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .busy(d_busy), .rnd_valid(d_valid), .rnd_out(d_out),
    .rnd_fallback(d_fb), .lfsr_state(d_lfsr));

  lfsr_range_rng #(.RANGE(3)) u_r3 (
    .CLOCK_50(CLOCK_50), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .busy(t_busy), .rnd_valid(t_valid), .rnd_out(t_out),
    .rnd_fallback(t_fb), .lfsr_state(t_lfsr));

  lfsr_range_rng #(.RANGE(1), .MAX_TRIES(2)) u_r1 (
    .CLOCK_50(CLOCK_50), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .busy(o_busy), .rnd_valid(o_valid), .rnd_out(o_out),
    .rnd_fallback(o_fb), .lfsr_state(o_lfsr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; the reference LFSR and default-instance FSM follow the
  // inputs as driven before the edge, and results are queued as they are due.
  task automatic tick();
    logic [15:0] nxt;
    if (reset) nxt = 16'hACE1;
    else if (seed_load) nxt = (seed_in == 16'h0) ? 16'h0001 : seed_in;
    else if (m_lfsr == 16'h0) nxt = 16'h0001;
    else nxt = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    if (reset) m_busy = 1'b0;
    else if (m_busy) begin
      q_def.push_back(m_lfsr[1:0]);
      m_busy = 1'b0;
    end else if (req) m_busy = 1'b1;
    @(posedge CLOCK_50);
    m_lfsr = nxt;
    #1;
  endtask

  always @(negedge CLOCK_50) begin
    if (d_valid === 1'b1) begin
      valid_cnt++;
      if (q_def.size() == 0) chk("def_unexpected_valid", 32'(d_out), 32'hDEAD);
      else chk("def_rnd_out", 32'(d_out), 32'(q_def.pop_front()));
      chk("def_no_fallback", 32'(d_fb), 32'h0);
    end
    if (t_valid === 1'b1) chk("r3_in_range", 32'(t_out < 2'd3), 32'h1);
    if (o_valid === 1'b1) chk("r1_out_zero", 32'(o_out), 32'h0);
  end

  initial begin
    m_lfsr = 16'hxxxx;
    m_busy = 1'b0;

    // Reset and free-running sequence
    reset = 1'b1;
    tick();
    tick();
    chk("reset_lfsr", 32'(d_lfsr), 32'hACE1);
    chk("reset_outputs", {28'h0, d_busy, d_valid, d_fb, |d_out}, 32'h0);
    reset = 1'b0;
    tick();
    chk("lfsr_step1", 32'(d_lfsr), 32'h59C3);
    chk("lfsr_step1_outputs", {28'h0, d_busy, d_valid, d_fb, |d_out}, 32'h0);
    tick();
    chk("lfsr_step2", 32'(d_lfsr), 32'hB387);
    chk("lfsr_step2_outputs", {28'h0, d_busy, d_valid, d_fb, |d_out}, 32'h0);

    // Zero seed replaced by 1
    seed_load = 1'b1;
    seed_in = 16'h0000;
    tick();
    seed_load = 1'b0;
    chk("zero_seed_load", 32'(d_lfsr), 32'h0001);
    tick();
    chk("zero_seed_shift", 32'(d_lfsr), 32'h0002);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (d_lfsr == 16'h0) chk("lfsr_nonzero", 32'(d_lfsr), 32'h1);
    end
    chk("lfsr_tracks_model", 32'(d_lfsr), 32'(m_lfsr));

    // Reseed with request: RANGE=3 rejects then accepts, RANGE=1 falls back
    seed_load = 1'b1;
    seed_in = 16'h0003;
    req = 1'b1;
    tick();
    seed_load = 1'b0;
    req = 1'b0;
    chk("r3_busy_n", 32'(t_busy), 32'h1);
    chk("r3_lfsr_n", 32'(t_lfsr), 32'h0003);
    tick();
    chk("r3_busy_after_reject", 32'(t_busy), 32'h1);
    chk("r3_no_valid_after_reject", 32'(t_valid), 32'h0);
    chk("r3_lfsr_n2", 32'(t_lfsr), 32'h0006);
    chk("r1_no_valid_after_reject", 32'(o_valid), 32'h0);
    tick();
    chk("r3_valid", 32'(t_valid), 32'h1);
    chk("r3_out", 32'(t_out), 32'h2);
    chk("r3_fallback", 32'(t_fb), 32'h0);
    chk("r3_busy_done", 32'(t_busy), 32'h0);
    chk("r1_valid", 32'(o_valid), 32'h1);
    chk("r1_out", 32'(o_out), 32'h0);
    chk("r1_fallback", 32'(o_fb), 32'h1);
    tick();
    chk("r3_valid_pulse", 32'(t_valid), 32'h0);
    chk("r1_fallback_pulse", {30'h0, o_valid, o_fb}, 32'h0);
    tick();

    // Held request on the default instance: one result every two cycles
    valid_cnt = 0;
    req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("held_busy", 32'(d_busy), 32'(m_busy));
    end
    req = 1'b0;
    tick();
    chk("held_valid_count", 32'(valid_cnt), 32'd10);

    // Request pulses while busy are ignored
    tick();
    valid_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      req = 1'b1;
      tick();
      req = (i % 2 == 0);
      tick();
      req = 1'b0;
      tick();
    end
    tick();
    chk("pulsed_valid_count", 32'(valid_cnt), 32'd6);

    // Reset in the middle of a request
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("mid_busy", 32'(d_busy), 32'h1);
    reset = 1'b1;
    tick();
    chk("abort_busy", 32'(d_busy), 32'h0);
    chk("abort_valid", 32'(d_valid), 32'h0);
    chk("abort_lfsr", 32'(d_lfsr), 32'hACE1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_no_stale_valid", 32'(d_valid | t_valid | o_valid), 32'h0);
    chk("scoreboard_drained", 32'(q_def.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
